// File: rtl/snake_pkg.sv
// Shared definitions for the snake command controller and the snake game core.
// Holds the direction encoding, the ASCII command bytes, the controller state
// type and a small case-folding helper used by the byte decoder.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Lower-case forms; the decoder folds upper-case letters before comparing.
  localparam logic [7:0] CMD_UP      = 8'h77; // 'w'
  localparam logic [7:0] CMD_RIGHT   = 8'h64; // 'd'
  localparam logic [7:0] CMD_DOWN    = 8'h73; // 's'
  localparam logic [7:0] CMD_LEFT    = 8'h61; // 'a'
  localparam logic [7:0] CMD_PAUSE   = 8'h70; // 'p'
  localparam logic [7:0] CMD_RESTART = 8'h72; // 'r'
  localparam logic [7:0] CMD_FASTER  = 8'h2B; // '+'
  localparam logic [7:0] CMD_SLOWER  = 8'h2D; // '-'

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/snake_cmd_ctrl_if.sv
// Bundle between the UART receiver / game core and the command controller.
//   rx_data, rx_wr : received byte and its one-cycle strobe (into controller)
//   dir, step, game_rst, paused, running, speed, fifo_level, overflow :
//                    game-side outputs of the controller
// slave  : controller side.   master : UART + game core side.
interface snake_cmd_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  logic [7:0]                   rx_data;
  logic                         rx_wr;
  logic [1:0]                   dir;
  logic                         step;
  logic                         game_rst;
  logic                         paused;
  logic                         running;
  logic [1:0]                   speed;
  logic [$clog2(DEPTH+1)-1:0]   fifo_level;
  logic                         overflow;

  modport slave (
    input  rx_data, rx_wr,
    output dir, step, game_rst, paused, running, speed, fifo_level, overflow
  );

  modport master (
    output rx_data, rx_wr,
    input  dir, step, game_rst, paused, running, speed, fifo_level, overflow
  );
endinterface

// File: rtl/snake_cmd_ctrl_cmd_fifo.sv
// cmd_fifo: synchronous DEPTH x 2-bit FIFO for queued direction commands.
//   push/din  : write one entry (accepted when not full, or when popping too)
//   pop/dout  : read one entry; dout is first-word-fall-through
//   flush     : empty the FIFO (wins over push/pop)
//   empty/full/level : occupancy, derived from the registered level count
module cmd_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [1:0]    din,
  output logic [1:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  // A push into a full FIFO still succeeds when an entry leaves in the same cycle.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/snake_cmd_ctrl.sv
// snake_cmd_ctrl: decodes UART bytes into snake game commands, queues direction
// keys, generates the game tick and releases at most one direction per tick.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : rx_data/rx_wr in; dir, step, game_rst, paused, running, speed,
//              fifo_level, overflow out (all registered)
module snake_cmd_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TICK_BASE = 1_250_000
) (
  input logic            clk,
  input logic            rst,
  snake_cmd_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(TICK_BASE * 8);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  // Last counter value per speed level: period is TICK_BASE << (3 - speed).
  localparam logic [CW-1:0] LAST0 = CW'(TICK_BASE * 8 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(TICK_BASE * 4 - 1);
  localparam logic [CW-1:0] LAST2 = CW'(TICK_BASE * 2 - 1);
  localparam logic [CW-1:0] LAST3 = CW'(TICK_BASE - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tick_last;
  logic [1:0]    dir_q;
  logic [1:0]    speed_q;
  logic          step_q;
  logic          game_rst_q;
  logic          paused_q;
  logic          running_q;
  logic          overflow_q;

  logic [7:0]    cmd;
  logic          is_dir;
  logic [1:0]    cmd_dir;
  logic          is_pause;
  logic          is_restart;
  logic          is_faster;
  logic          is_slower;
  logic          faster_ok;
  logic          slower_ok;
  logic          tick;
  logic          push;
  logic          pop;

  logic [1:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;

  assign cmd = to_lower(bus.rx_data);

  always_comb begin
    is_dir     = 1'b0;
    cmd_dir    = DIR_RIGHT;
    is_pause   = 1'b0;
    is_restart = 1'b0;
    is_faster  = 1'b0;
    is_slower  = 1'b0;
    if (bus.rx_wr) begin
      case (cmd)
        CMD_UP:      begin is_dir = 1'b1; cmd_dir = DIR_UP;    end
        CMD_RIGHT:   begin is_dir = 1'b1; cmd_dir = DIR_RIGHT; end
        CMD_DOWN:    begin is_dir = 1'b1; cmd_dir = DIR_DOWN;  end
        CMD_LEFT:    begin is_dir = 1'b1; cmd_dir = DIR_LEFT;  end
        CMD_PAUSE:   is_pause   = 1'b1;
        CMD_RESTART: is_restart = 1'b1;
        CMD_FASTER:  is_faster  = 1'b1;
        CMD_SLOWER:  is_slower  = 1'b1;
        default:     ;
      endcase
    end
  end

  always_comb begin
    case (speed_q)
      2'd0:    tick_last = LAST0;
      2'd1:    tick_last = LAST1;
      2'd2:    tick_last = LAST2;
      default: tick_last = LAST3;
    endcase
  end

  assign tick      = (state == ST_RUN) && (cnt == tick_last);
  assign push      = is_dir && (state == ST_RUN);
  assign pop       = tick && !fifo_empty;
  assign faster_ok = is_faster && (state != ST_IDLE) && (speed_q != 2'd3);
  assign slower_ok = is_slower && (state != ST_IDLE) && (speed_q != 2'd0);

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (is_restart),
    .din   (cmd_dir),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dir_q      <= DIR_RIGHT;
      speed_q    <= 2'd1;
      step_q     <= 1'b0;
      game_rst_q <= 1'b0;
      paused_q   <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      step_q     <= 1'b0;
      game_rst_q <= 1'b0;
      if (is_restart) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        dir_q      <= DIR_RIGHT;
        game_rst_q <= 1'b1;
        paused_q   <= 1'b0;
        running_q  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (is_dir) begin
              state     <= ST_RUN;
              cnt       <= '0;
              dir_q     <= cmd_dir;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (tick) begin
              cnt    <= '0;
              step_q <= 1'b1;
              // A queued key opposite to the current heading is dropped.
              if (pop && (fifo_dout != (dir_q ^ 2'b10))) begin
                dir_q <= fifo_dout;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
            if (push && fifo_full && !pop) begin
              overflow_q <= 1'b1;
            end
            if (is_pause) begin
              state     <= ST_PAUSE;
              running_q <= 1'b0;
              paused_q  <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (is_pause) begin
              state     <= ST_RUN;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
        // Placed after the state case so a speed change wins the counter update.
        if (faster_ok) begin
          speed_q <= speed_q + 2'd1;
          cnt     <= '0;
        end else if (slower_ok) begin
          speed_q <= speed_q - 2'd1;
          cnt     <= '0;
        end
      end
    end
  end

  assign bus.dir        = dir_q;
  assign bus.step       = step_q;
  assign bus.game_rst   = game_rst_q;
  assign bus.paused     = paused_q;
  assign bus.running    = running_q;
  assign bus.speed      = speed_q;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_snake_cmd_ctrl.sv
// Self-checking bench for snake_cmd_ctrl with TICK_BASE=4, DEPTH=4.
// Stimulus queues the expected step/game_rst pulses (cycle, kind, dir); a
// monitor pops and compares each pulse as the DUT presents it.
module tb_snake_cmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit         is_rst;
    logic [1:0] d;
    int         c;
  } exp_t;

  exp_t q[$];

  snake_cmd_ctrl_if #(.DEPTH(4)) bus ();

  snake_cmd_ctrl #(
    .DEPTH     (4),
    .TICK_BASE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_step(input int c, input logic [1:0] d);
    q.push_back('{1'b0, d, c});
  endtask

  task automatic expect_game_rst(input int c);
    q.push_back('{1'b1, 2'b00, c});
  endtask

  // Drive byte b during cycle c; returns at #1 after the edge ending cycle c.
  task automatic send_at(input int c, input logic [7:0] b);
    chk("schedule", 32'(cyc < c), 32'd1);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    bus.rx_data = b;
    bus.rx_wr   = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_wr   = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.step === 1'b1 || bus.game_rst === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: cycle %0d step=%b game_rst=%b required no pulse",
                   cyc, bus.step, bus.game_rst);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(e.c));
          chk("pulse_step", 32'(bus.step), 32'(!e.is_rst));
          chk("pulse_game_rst", 32'(bus.game_rst), 32'(e.is_rst));
          if (!e.is_rst) chk("step_dir", 32'(bus.dir), 32'(e.d));
        end
      end
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_dir", 32'(bus.dir), 32'd1);
    chk("rst_speed", 32'(bus.speed), 32'd1);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_paused", 32'(bus.paused), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_step", 32'(bus.step), 32'd0);
    chk("rst_game_rst", 32'(bus.game_rst), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, t0, tq, tg;
    bus.rx_data = 8'h00;
    bus.rx_wr   = 1'b0;
    fork
      monitor();
    join_none

    // Reset and idle: ignored commands, no pulses.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values();
    rst = 1'b0;
    base = cyc;
    send_at(base + 5, "+");
    send_at(base + 10, "p");
    wait_until(base + 100);
    chk("idle_speed", 32'(bus.speed), 32'd1);
    chk("idle_paused", 32'(bus.paused), 32'd0);
    chk("idle_running", 32'(bus.running), 32'd0);
    chk("idle_dir", 32'(bus.dir), 32'd1);

    // Start with 'D', queue w and a; P = 16 at speed 1.
    t0 = base + 110;
    expect_step(t0 + 17, 2'b00);
    expect_step(t0 + 33, 2'b11);
    expect_step(t0 + 49, 2'b11);
    expect_step(t0 + 65, 2'b00);
    expect_step(t0 + 81, 2'b00);
    expect_step(t0 + 97, 2'b01);
    expect_step(t0 + 113, 2'b01);
    send_at(t0, "D");
    chk("start_running", 32'(bus.running), 32'd1);
    chk("start_dir", 32'(bus.dir), 32'd1);
    send_at(t0 + 2, "w");
    send_at(t0 + 4, "a");
    chk("queued_two", 32'(bus.fifo_level), 32'd2);

    // Reverse key while heading left is discarded at the pop.
    send_at(t0 + 35, "d");
    chk("rev_level_1", 32'(bus.fifo_level), 32'd1);
    wait_until(t0 + 50);
    chk("rev_level_0", 32'(bus.fifo_level), 32'd0);
    chk("rev_dir", 32'(bus.dir), 32'd3);

    // Five keys within one period: fifth overflows.
    send_at(t0 + 51, "w");
    send_at(t0 + 53, "s");
    send_at(t0 + 55, "d");
    send_at(t0 + 57, "A");
    send_at(t0 + 59, "w");
    chk("ovf_level", 32'(bus.fifo_level), 32'd4);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    wait_until(t0 + 114);
    chk("drain_level", 32'(bus.fifo_level), 32'd0);
    chk("drain_overflow", 32'(bus.overflow), 32'd1);
    chk("drain_dir", 32'(bus.dir), 32'd1);

    // Pause with counter at 7 -> frozen at 8; resume needs 8 more cycles.
    send_at(t0 + 120, "p");
    chk("pause_paused", 32'(bus.paused), 32'd1);
    chk("pause_running", 32'(bus.running), 32'd0);
    send_at(t0 + 130, "w");
    chk("pause_drop", 32'(bus.fifo_level), 32'd0);
    tq = t0 + 225;
    expect_step(tq + 9, 2'b01);
    send_at(tq, "P");
    chk("resume_running", 32'(bus.running), 32'd1);
    chk("resume_paused", 32'(bus.paused), 32'd0);

    // Speed to 3 (P = 4); extra '+' at the limit must not clear the counter.
    expect_step(tq + 18, 2'b01);
    expect_step(tq + 22, 2'b01);
    expect_step(tq + 26, 2'b01);
    expect_game_rst(tq + 27);
    send_at(tq + 11, "+");
    chk("speed_2", 32'(bus.speed), 32'd2);
    send_at(tq + 13, "+");
    send_at(tq + 15, "+");
    send_at(tq + 17, "+");
    send_at(tq + 19, "+");
    chk("speed_sat", 32'(bus.speed), 32'd3);
    wait_until(tq + 21);
    send_at(tq + 22, "a");
    send_at(tq + 24, "a");
    chk("pre_flush_level", 32'(bus.fifo_level), 32'd2);
    send_at(tq + 26, "R");
    chk("restart_running", 32'(bus.running), 32'd0);
    chk("restart_paused", 32'(bus.paused), 32'd0);
    chk("restart_dir", 32'(bus.dir), 32'd1);
    chk("restart_level", 32'(bus.fifo_level), 32'd0);
    chk("restart_speed", 32'(bus.speed), 32'd3);
    chk("restart_overflow", 32'(bus.overflow), 32'd1);

    // IDLE accepts the reverse of 01 directly; rst mid-count overrides 'p'.
    tg = tq + 40;
    expect_step(tg + 5, 2'b10);
    send_at(tg, "s");
    chk("idle_no_rev_check", 32'(bus.dir), 32'd2);
    send_at(tg + 2, "w");
    send_at(tg + 6, "a");
    chk("pre_rst_dir", 32'(bus.dir), 32'd2);
    chk("pre_rst_level", 32'(bus.fifo_level), 32'd1);
    bus.rx_data = "p";
    bus.rx_wr   = 1'b1;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.rx_wr = 1'b0;
    chk_reset_values();
    wait_until(tg + 40);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_cmd_ctrl.md
# snake_cmd_ctrl

Command scheduler between the UART receiver and the snake game core. It decodes received ASCII bytes into direction, pause, restart and speed commands, and buffers direction commands in a small FIFO. It generates the game tick and releases at most one direction per tick, so fast keystrokes are neither lost nor applied within the same move. It replaces the direct byte-to-game path and owns game-level sequencing: idle, running and paused.

## Interface
- `DEPTH`, 4: direction FIFO depth in entries; must be a power of two, 2 or more.
- `TICK_BASE`, 1_250_000: tick period in clk cycles at the fastest speed (20 Hz at 25 MHz).
- `clk` in 1: system clock, 25 MHz.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `rx_data` in 8: received byte; valid only while `rx_wr`=1.
- `rx_wr` in 1: one-cycle strobe from the UART receiver.
- `dir` out 2: current direction; 00 up, 01 right, 10 down, 11 left.
- `step` out 1: one-cycle pulse; the snake advances one cell.
- `game_rst` out 1: one-cycle pulse; the game core clears its board.
- `paused` out 1: high in PAUSE.
- `running` out 1: high in RUN.
- `speed` out 2: speed level; 0 is slowest, 3 is fastest.
- `fifo_level` out $clog2(DEPTH+1): number of queued direction commands.
- `overflow` out 1: sticky; set when a direction is dropped because the FIFO is full.

## Operation
- Reset values:
  - state IDLE; `dir`=01; `speed`=1.
  - `step`, `game_rst`, `paused`, `running`, `overflow` = 0.
  - FIFO empty; tick counter 0.
- Byte decoding is case-insensitive:
  - `w` = up, `d` = right, `s` = down, `a` = left.
  - `p` toggles pause; `r` restarts.
  - `+` raises speed, `-` lowers speed.
  - Any other byte is ignored.
- IDLE:
  - A direction byte loads `dir` directly, with no reversal check, and enters RUN. The tick counter clears to 0.
  - `p`, `+` and `-` are ignored.
- RUN:
  - Direction bytes are pushed to the FIFO. If the FIFO is full, the byte is dropped and `overflow` is set.
  - The tick counter counts 0 to P-1, where P = TICK_BASE << (3-speed).
  - On the cycle the counter reaches P-1:
    - the counter wraps to 0;
    - `step` pulses;
    - if the FIFO is non-empty, one entry is popped.
  - A popped direction equal to the reverse of `dir` (difference of 2, mod 4) is discarded and `dir` is unchanged. Any other popped value is loaded into `dir`.
  - `p` moves to PAUSE.
- PAUSE:
  - The tick counter is frozen. FIFO contents are kept.
  - Direction bytes are dropped; they are not queued and do not set `overflow`.
  - `p` returns to RUN; counting resumes from the frozen value.
- `r` in any state:
  - flushes the FIFO;
  - sets `dir`=01 and clears the counter;
  - pulses `game_rst`;
  - moves to IDLE.
  - `speed` and `overflow` are kept.
- `+` and `-`:
  - accepted in RUN and PAUSE;
  - saturate at 3 and at 0;
  - a speed change clears the tick counter, even in PAUSE.
  - At the limit the speed is unchanged and the counter is not cleared.
- Push and pop in the same cycle: both occur and `fifo_level` is unchanged. A push while full but popping in the same cycle succeeds.
- `overflow` clears only on `rst`.
- Synchronous `rst` mid-operation overrides every other event in that cycle.

## Timing
- `rx_wr` at cycle T:
  - state, FIFO, `speed`, `paused`/`running` and `fifo_level` are updated at T+1;
  - `game_rst` is high during T+1 only.
- Tick at cycle T (counter = P-1):
  - `step` is high during T+1 only;
  - the new `dir` is valid from T+1, so it is coincident with `step`.
- IDLE to RUN on a direction byte at T: the first `step` is at T+1+P.
- `rx_wr` coinciding with a tick at T: the byte's push and the tick's pop are both evaluated at T. A byte pushed into an empty FIFO at T is not popped until the next tick.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Sustained throughput: one command per clk is accepted by decode; one direction is consumed per tick.

## Structure
- `snake_pkg` holds:
  - direction encoding constants `DIR_UP`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT`;
  - ASCII command constants;
  - the state enum (IDLE, RUN, PAUSE).
  - The snake core shares the direction constants.
- Sub-module `cmd_fifo`:
  - synchronous FIFO, DEPTH x 2 bits;
  - ports: push, pop, flush, din, dout, empty, full, level;
  - pointer wrap via a power-of-two index;
  - first-word-fall-through `dout`.
- The tick counter, decoder and state machine stay in `snake_cmd_ctrl`.

## Test plan
All scenarios use TICK_BASE=4 and DEPTH=4.
- Reset, then idle for 100 cycles -> `dir`=01, `running`=0, no `step` or `game_rst` pulse, `speed`=1.
- `d` at T0 -> RUN at T0+1. `step` pulses every 16 cycles starting T0+17. `w`,`a` queued -> `dir`=00 at the next step, then 11 at the following step.
- In RUN with `dir`=01, send `a` -> the pop at the next tick discards it; `dir` stays 01; `fifo_level` 1 to 0.
- Send 5 direction bytes in RUN within one tick period -> `fifo_level`=4 and `overflow`=1. After 4 ticks `fifo_level`=0 and `overflow` is still 1.
- `p` mid-count -> no `step` for 100 cycles. `p` again -> the first `step` arrives after the remaining count. `w` sent while paused is dropped.
- `+` x5 -> `speed` saturates at 3 and the period is 4. `r` -> `game_rst` for 1 cycle, IDLE, `dir`=01, `fifo_level`=0, `speed` stays 3. `rst` asserted mid-tick -> all reset values at the next edge.
